// File: rtl/mem_access_unit.sv
// Load/store stage between the RV32I execute logic and a word-wide req/ack data memory.
// It checks funct3 and alignment, issues one byte-enabled transaction, and returns the extended load value or a halt.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_halt,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2,
        S_ERROR  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [1:0]         off_q, off_d;
    logic               store_q, store_d;
    logic               req_ready_q, req_ready_d;
    logic               busy_q, busy_d;
    logic               resp_valid_q, resp_valid_d;
    logic [31:0]        resp_rdata_q, resp_rdata_d;
    logic               resp_halt_q, resp_halt_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [3:0]         mem_be_q, mem_be_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;

    logic               legal_c;
    logic [3:0]         be_c;
    logic [31:0]        wdata_c;
    logic [31:0]        shifted_c;
    logic [31:0]        load_c;

    // Request legality: funct3 encoding per direction, then natural alignment.
    always_comb begin
        legal_c = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: legal_c = 1'b1;
            3'b100, 3'b101:         legal_c = !req_store;
            default:                legal_c = 1'b0;
        endcase
        if (req_funct3[1:0] == 2'b01 && req_addr[0] != 1'b0) begin
            legal_c = 1'b0;
        end
        if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) begin
            legal_c = 1'b0;
        end
    end

    // Byte lanes and replicated store data for the incoming request.
    always_comb begin
        case (req_funct3[1:0])
            2'b00: begin
                be_c    = 4'b0001 << req_addr[1:0];
                wdata_c = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be_c    = 4'b0011 << req_addr[1:0];
                wdata_c = {2{req_wdata[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = req_wdata;
            end
        endcase
    end

    // Load extraction: shift the addressed lane down, then sign/zero extend.
    always_comb begin
        shifted_c = mem_rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  load_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
            3'b001:  load_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
            3'b100:  load_c = {24'd0, shifted_c[7:0]};
            3'b101:  load_c = {16'd0, shifted_c[15:0]};
            default: load_c = mem_rdata;
        endcase
    end

    // Next-state and registered output computation.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        store_d      = store_q;
        resp_valid_d = 1'b0;
        resp_halt_d  = 1'b0;
        resp_rdata_d = resp_rdata_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    funct3_d = req_funct3;
                    off_d    = req_addr[1:0];
                    store_d  = req_store;
                    cnt_d    = '0;
                    if (legal_c) begin
                        state_d     = S_ACCESS;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_store;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_be_d    = be_c;
                        mem_wdata_d = wdata_c;
                    end else begin
                        state_d      = S_ERROR;
                        resp_valid_d = 1'b1;
                        resp_halt_d  = 1'b1;
                        resp_rdata_d = 32'd0;
                    end
                end
            end
            S_ACCESS: begin
                if (mem_ack) begin
                    state_d      = S_DONE;
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = store_q ? 32'd0 : load_c;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d      = S_ERROR;
                    cnt_d        = cnt_q + CNT_W'(1);
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_halt_d  = 1'b1;
                    resp_rdata_d = 32'd0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERROR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d      = (state_d != S_IDLE);
        req_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            funct3_q     <= 3'd0;
            off_q        <= 2'd0;
            store_q      <= 1'b0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_halt_q  <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_be_q     <= 4'd0;
            mem_wdata_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
            store_q      <= store_d;
            req_ready_q  <= req_ready_d;
            busy_q       <= busy_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_halt_q  <= resp_halt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign busy       = busy_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_halt  = resp_halt_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit: legal loads/stores, illegal requests, timeout and reset abort.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        busy;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_halt;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_cmp;
    int n_bad;

    mem_access_unit #(.TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .busy       (busy),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_halt  (resp_halt),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        step();
        req_valid  = 1'b0;
    endtask

    // Legal access acknowledged after ack_delay extra cycles of waiting.
    task automatic access_ok(input string tag, input logic st, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                             input int ack_delay, input logic [3:0] exp_be,
                             input logic [31:0] exp_wd, input logic [31:0] exp_rd);
        issue(st, f3, addr, wd);
        check({tag, ".mem_req"}, {31'd0, mem_req}, 32'd1);
        check({tag, ".busy"}, {31'd0, busy}, 32'd1);
        check({tag, ".ready"}, {31'd0, req_ready}, 32'd0);
        check({tag, ".we"}, {31'd0, mem_we}, {31'd0, st});
        check({tag, ".addr"}, mem_addr, {addr[31:2], 2'b00});
        check({tag, ".be"}, {28'd0, mem_be}, {28'd0, exp_be});
        if (st) check({tag, ".wdata"}, mem_wdata, exp_wd);
        for (int i = 0; i < ack_delay; i++) begin
            step();
            check({tag, ".req_hold"}, {31'd0, mem_req}, 32'd1);
            check({tag, ".no_resp"}, {31'd0, resp_valid}, 32'd0);
        end
        mem_ack   = 1'b1;
        mem_rdata = rd;
        step();
        mem_ack   = 1'b0;
        check({tag, ".resp_valid"}, {31'd0, resp_valid}, 32'd1);
        check({tag, ".halt"}, {31'd0, resp_halt}, 32'd0);
        check({tag, ".rdata"}, resp_rdata, exp_rd);
        check({tag, ".req_drop"}, {31'd0, mem_req}, 32'd0);
        step();
        check({tag, ".pulse"}, {31'd0, resp_valid}, 32'd0);
        check({tag, ".idle"}, {31'd0, req_ready}, 32'd1);
    endtask

    task automatic access_bad(input string tag, input logic st, input logic [2:0] f3,
                              input logic [31:0] addr);
        issue(st, f3, addr, 32'hFFFF_FFFF);
        check({tag, ".mem_req"}, {31'd0, mem_req}, 32'd0);
        check({tag, ".resp_valid"}, {31'd0, resp_valid}, 32'd1);
        check({tag, ".halt"}, {31'd0, resp_halt}, 32'd1);
        check({tag, ".rdata"}, resp_rdata, 32'd0);
        check({tag, ".ready"}, {31'd0, req_ready}, 32'd0);
        step();
        check({tag, ".pulse"}, {31'd0, resp_valid}, 32'd0);
        check({tag, ".idle"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        int n;
        n_cmp      = 0;
        n_bad      = 0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        mem_ack    = 1'b0;
        mem_rdata  = 32'd0;
        step();
        step();
        check("rst.ready", {31'd0, req_ready}, 32'd1);
        check("rst.busy", {31'd0, busy}, 32'd0);
        check("rst.mem_req", {31'd0, mem_req}, 32'd0);
        check("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst.be", {28'd0, mem_be}, 32'd0);
        check("rst.addr", mem_addr, 32'd0);
        rst = 1'b0;
        step();

        access_ok("lw", 1'b0, 3'b010, 32'h100, 32'd0, 32'hDEAD_BEEF, 0, 4'b1111, 32'd0, 32'hDEAD_BEEF);
        access_ok("lb", 1'b0, 3'b000, 32'h103, 32'd0, 32'h8011_2233, 0, 4'b1000, 32'd0, 32'hFFFF_FF80);
        access_ok("lbu", 1'b0, 3'b100, 32'h103, 32'd0, 32'h8011_2233, 0, 4'b1000, 32'd0, 32'h0000_0080);
        access_ok("lh", 1'b0, 3'b001, 32'h102, 32'd0, 32'h8011_2233, 1, 4'b1100, 32'd0, 32'hFFFF_8011);
        access_ok("lhu", 1'b0, 3'b101, 32'h102, 32'd0, 32'h8011_2233, 0, 4'b1100, 32'd0, 32'h0000_8011);
        access_ok("lb0", 1'b0, 3'b000, 32'h200, 32'd0, 32'h1122_337F, 0, 4'b0001, 32'd0, 32'h0000_007F);
        access_ok("sh", 1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 32'h5555_5555, 2, 4'b1100, 32'hABCD_ABCD, 32'd0);
        access_ok("sb", 1'b1, 3'b000, 32'h301, 32'hFFFF_FF5A, 32'd0, 0, 4'b0010, 32'h5A5A_5A5A, 32'd0);
        access_ok("sw", 1'b1, 3'b010, 32'h404, 32'hCAFE_F00D, 32'd0, 0, 4'b1111, 32'hCAFE_F00D, 32'd0);

        access_bad("lw_mis", 1'b0, 3'b010, 32'h101);
        access_bad("lh_mis", 1'b0, 3'b001, 32'h103);
        access_bad("sw_f3", 1'b1, 3'b011, 32'h100);
        access_bad("ld_f3", 1'b0, 3'b110, 32'h100);
        access_bad("sbu_f3", 1'b1, 3'b100, 32'h100);

        // Ack withheld: mem_req must stay up exactly TIMEOUT cycles.
        issue(1'b0, 3'b010, 32'h500, 32'd0);
        n = 0;
        while (mem_req && n < 40) begin
            n++;
            step();
        end
        check("to.req_cycles", 32'(n), 32'd16);
        check("to.resp_valid", {31'd0, resp_valid}, 32'd1);
        check("to.halt", {31'd0, resp_halt}, 32'd1);
        check("to.rdata", resp_rdata, 32'd0);
        step();
        check("to.idle", {31'd0, req_ready}, 32'd1);
        access_ok("to.next", 1'b0, 3'b100, 32'h601, 32'd0, 32'h0000_9900, 0, 4'b0010, 32'd0, 32'h0000_0099);

        // Reset while ACCESS is waiting on ack; later ack must be ignored.
        issue(1'b0, 3'b010, 32'h700, 32'd0);
        check("rs.mem_req", {31'd0, mem_req}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rs.mem_req_off", {31'd0, mem_req}, 32'd0);
        check("rs.no_resp", {31'd0, resp_valid}, 32'd0);
        check("rs.ready", {31'd0, req_ready}, 32'd1);
        check("rs.busy", {31'd0, busy}, 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        step();
        mem_ack   = 1'b0;
        check("rs.late_ack", {31'd0, resp_valid}, 32'd0);
        check("rs.late_busy", {31'd0, busy}, 32'd0);
        step();
        check("rs.late_ack2", {31'd0, resp_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
